// File: rtl/chip8_pkg.sv
// Shared types and default geometry for the Chip-8 framebuffer engine.
package chip8_pkg;

  localparam int FB_W_DEF = 64;
  localparam int FB_H_DEF = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_XOR   = 2'd2,
    OP_READ  = 2'd3
  } fb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XOR_WB = 2'd1,
    ST_CLEAR  = 2'd2
  } fb_state_t;

endpackage

// File: rtl/chip8_fb_ram.sv
// One-bit-per-pixel framebuffer: read/write port A (CPU/engine), read-only
// port B (scanout). Both read ports are registered and read-before-write,
// so a same-address write and read in one cycle return the old pixel.
module chip8_fb_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a_addr_i,
  input  logic          a_we_i,
  input  logic          a_wdata_i,
  output logic          a_rdata_o,
  input  logic [AW-1:0] b_addr_i,
  output logic          b_rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic mem [DEPTH];
  logic a_rdata_q;
  logic b_rdata_q;

  // Pixel storage is deliberately not reset; only CLEAR zeroes it.
  always_ff @(posedge clk) begin
    if (a_we_i) mem[a_addr_i] <= a_wdata_i;
  end

  // Registered read data for both ports, zeroed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q <= 1'b0;
      b_rdata_q <= 1'b0;
    end else begin
      a_rdata_q <= mem[a_addr_i];
      b_rdata_q <= mem[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/chip8_fb_engine.sv
// Chip-8 framebuffer engine: CPU pixel WRITE/XOR/READ with sticky collision
// flag, full-screen hardware clear, and an independent scanout read port.
module chip8_fb_engine
  import chip8_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fb_req_i,
  input  logic [1:0]              fb_op_i,
  input  logic [$clog2(FB_W)-1:0] fb_addr_x_i,
  input  logic [$clog2(FB_H)-1:0] fb_addr_y_i,
  input  logic                    fb_writedata_i,
  output logic                    fb_ready_o,
  output logic                    fb_readdata_o,
  output logic                    fb_rvalid_o,
  output logic                    fb_collision_o,
  input  logic                    fb_collision_clr_i,
  input  logic                    fb_clear_i,
  output logic                    fb_busy_o,
  output logic                    fb_clear_done_o,
  input  logic [$clog2(FB_W)-1:0] scan_addr_x_i,
  input  logic [$clog2(FB_H)-1:0] scan_addr_y_i,
  output logic                    scan_pixel_o
);

  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int AW = XW + YW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);

  fb_state_t     state_q;
  logic          pend_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] xaddr_q;
  logic          xdata_q;
  logic          rvalid_q;
  logic          coll_q;
  logic          done_q;

  fb_op_t        op;
  logic [AW-1:0] cpu_addr;
  logic          accept;
  logic          coll_set;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_wdata;
  logic          ram_rdata;

  assign op         = fb_op_t'(fb_op_i);
  assign cpu_addr   = {fb_addr_y_i, fb_addr_x_i};
  // A clear request (new or pending) always wins over a CPU request.
  assign fb_ready_o = (state_q == ST_IDLE) && !fb_clear_i && !pend_q && !reset;
  assign accept     = fb_req_i && fb_ready_o;
  // ram_rdata holds the old pixel captured on the XOR accept edge.
  assign coll_set   = (state_q == ST_XOR_WB) && ram_rdata && xdata_q;

  // Port A mux: XOR writeback, clear counter, or direct CPU access.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = 1'b0;
    ram_wdata = fb_writedata_i;
    case (state_q)
      ST_XOR_WB: begin
        ram_addr  = xaddr_q;
        ram_we    = !reset;
        ram_wdata = ram_rdata ^ xdata_q;
      end
      ST_CLEAR: begin
        ram_addr  = cnt_q;
        ram_we    = !reset;
        ram_wdata = 1'b0;
      end
      default: ram_we = accept && (op == OP_WRITE);
    endcase
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      xaddr_q  <= '0;
      xdata_q  <= 1'b0;
      rvalid_q <= 1'b0;
      coll_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= accept && (op == OP_READ);
      done_q   <= 1'b0;
      if (coll_set)                coll_q <= 1'b1;
      else if (fb_collision_clr_i) coll_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fb_clear_i || pend_q) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end else if (accept && (op == OP_XOR)) begin
            state_q <= ST_XOR_WB;
            xaddr_q <= cpu_addr;
            xdata_q <= fb_writedata_i;
          end
        end
        ST_XOR_WB: begin
          state_q <= ST_IDLE;
          if (fb_clear_i) pend_q <= 1'b1;
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  chip8_fb_ram #(.AW(AW)) u_ram (
    .clk       (clk),
    .reset     (reset),
    .a_addr_i  (ram_addr),
    .a_we_i    (ram_we),
    .a_wdata_i (ram_wdata),
    .a_rdata_o (ram_rdata),
    .b_addr_i  ({scan_addr_y_i, scan_addr_x_i}),
    .b_rdata_o (scan_pixel_o)
  );

  assign fb_readdata_o   = ram_rdata;
  assign fb_rvalid_o     = rvalid_q;
  assign fb_collision_o  = coll_q;
  assign fb_busy_o       = (state_q == ST_CLEAR);
  assign fb_clear_done_o = done_q;

endmodule

// File: tb/tb_chip8_fb_engine.sv
// Self-checking bench: 64x32 instance against a pixel-array model, plus a
// 128x64 instance for large-geometry and reset-during-clear behaviour.
module tb_chip8_fb_engine;

  localparam logic [1:0] T_WRITE = 2'd1, T_XOR = 2'd2, T_READ = 2'd3;
  localparam int W = 64, H = 32, N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // 64x32 instance
  logic       reset = 1'b1, req = 1'b0, wd = 1'b0, cclr = 1'b0, clr = 1'b0;
  logic [1:0] op = 2'd0;
  logic [5:0] ax = '0, sx = '0;
  logic [4:0] ay = '0, sy = '0;
  logic       ready, rd, rvalid, coll, busy, done, spix;

  // 128x64 instance
  logic       reset2 = 1'b1, req2 = 1'b0, wd2 = 1'b0, clr2 = 1'b0;
  logic [1:0] op2 = 2'd0;
  logic [6:0] ax2 = '0, sx2 = '0;
  logic [5:0] ay2 = '0, sy2 = '0;
  logic       ready2, rd2, rvalid2, coll2, busy2, done2, spix2;

  chip8_fb_engine #(.FB_W(64), .FB_H(32)) u_dut (
    .clk(clk), .reset(reset), .fb_req_i(req), .fb_op_i(op),
    .fb_addr_x_i(ax), .fb_addr_y_i(ay), .fb_writedata_i(wd),
    .fb_ready_o(ready), .fb_readdata_o(rd), .fb_rvalid_o(rvalid),
    .fb_collision_o(coll), .fb_collision_clr_i(cclr), .fb_clear_i(clr),
    .fb_busy_o(busy), .fb_clear_done_o(done),
    .scan_addr_x_i(sx), .scan_addr_y_i(sy), .scan_pixel_o(spix));

  chip8_fb_engine #(.FB_W(128), .FB_H(64)) u_dut2 (
    .clk(clk), .reset(reset2), .fb_req_i(req2), .fb_op_i(op2),
    .fb_addr_x_i(ax2), .fb_addr_y_i(ay2), .fb_writedata_i(wd2),
    .fb_ready_o(ready2), .fb_readdata_o(rd2), .fb_rvalid_o(rvalid2),
    .fb_collision_o(coll2), .fb_collision_clr_i(1'b0), .fb_clear_i(clr2),
    .fb_busy_o(busy2), .fb_clear_done_o(done2),
    .scan_addr_x_i(sx2), .scan_addr_y_i(sy2), .scan_pixel_o(spix2));

  // Reference model: one bit per pixel indexed y*W+x, plus the sticky flag.
  bit mdl [N];
  bit mcoll = 1'b0;

  typedef struct {
    logic [1:0] op;
    int         x;
    int         y;
    logic       d;
    logic       exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One CPU transaction on the 64x32 instance, checked against the model.
  task automatic cpu_op(input logic [1:0] o, input int x, input int y, input logic d,
                        output logic r);
    int   i;
    logic old;
    i   = y * W + x;
    old = mdl[i];
    r   = 1'b0;
    @(negedge clk);
    req = 1'b1; op = o; ax = x[5:0]; ay = y[4:0]; wd = d;
    #1 chk("ready_idle", ready, 1);
    @(posedge clk); #1;
    req = 1'b0; op = 2'd0;
    if (cclr) mcoll = 1'b0;
    case (o)
      T_WRITE: begin
        mdl[i] = d;
        chk("rvalid_after_write", rvalid, 0);
      end
      T_READ: begin
        chk("rvalid", rvalid, 1);
        chk("readdata_model", rd, old);
        r = rd;
        @(posedge clk); #1;
        if (cclr) mcoll = 1'b0;
        chk("rvalid_one_cycle", rvalid, 0);
      end
      T_XOR: begin
        chk("ready_xor_wb", ready, 0);
        @(posedge clk); #1;
        mdl[i] = old ^ d;
        if (old && d) mcoll = 1'b1;
        else if (cclr) mcoll = 1'b0;
        chk("collision_model", coll, mcoll);
      end
      default: ;
    endcase
  endtask

  task automatic scan_chk(input string name, input int x, input int y);
    @(negedge clk);
    sx = x[5:0]; sy = y[4:0];
    @(posedge clk); #1 chk(name, spix, mdl[y * W + x]);
  endtask

  // Full clear with fb_clear held into CLEAR to show it is not restarted.
  task automatic do_clear();
    int n;
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 chk("busy_start", busy, 1);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      if (n == 3) clr = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_cycles", n, N);
    chk("done_pulse", done, 1);
    chk("ready_after_clear", ready, 1);
    @(posedge clk); #1;
    chk("done_low", done, 0);
    chk("no_restart", busy, 0);
    for (int i = 0; i < N; i++) mdl[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[11];
    logic r;
    int   n, bad;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_readdata", rd, 0);
    chk("rst_coll", coll, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan", spix, 0);
    @(negedge clk); reset = 1'b0;
    #1 chk("ready_after_reset", ready, 1);

    // Storage is not reset, so start from a known blank screen.
    do_clear();

    // Write/read vector table
    tbl[0]  = '{T_WRITE, 1, 1, 1'b1, 1'b0};
    tbl[1]  = '{T_WRITE, 2, 2, 1'b1, 1'b0};
    tbl[2]  = '{T_WRITE, 4, 4, 1'b1, 1'b0};
    tbl[3]  = '{T_WRITE, 8, 8, 1'b1, 1'b0};
    tbl[4]  = '{T_WRITE, 16, 16, 1'b1, 1'b0};
    tbl[5]  = '{T_READ, 1, 1, 1'b0, 1'b1};
    tbl[6]  = '{T_READ, 2, 2, 1'b0, 1'b1};
    tbl[7]  = '{T_READ, 4, 4, 1'b0, 1'b1};
    tbl[8]  = '{T_READ, 8, 8, 1'b0, 1'b1};
    tbl[9]  = '{T_READ, 16, 16, 1'b0, 1'b1};
    tbl[10] = '{T_READ, 3, 3, 1'b0, 1'b0};
    for (int k = 0; k < 11; k++) begin
      cpu_op(tbl[k].op, tbl[k].x, tbl[k].y, tbl[k].d, r);
      if (tbl[k].op == T_READ) chk("tbl_read", r, tbl[k].exp);
    end

    // XOR twice on the same pixel: second one collides
    cpu_op(T_XOR, 5, 5, 1'b1, r);  chk("xor1_coll", coll, 0);
    cpu_op(T_READ, 5, 5, 1'b0, r); chk("xor1_pixel", r, 1);
    cpu_op(T_XOR, 5, 5, 1'b1, r);  chk("xor2_coll", coll, 1);
    cpu_op(T_READ, 5, 5, 1'b0, r); chk("xor2_pixel", r, 0);
    // XOR with data 0 leaves pixel 1 alone and does not collide
    cclr = 1'b1;
    cpu_op(T_WRITE, 6, 6, 1'b1, r); chk("coll_cleared", coll, 0);
    cclr = 1'b0;
    cpu_op(T_XOR, 6, 6, 1'b0, r);  chk("xor0_coll", coll, 0);
    cpu_op(T_READ, 6, 6, 1'b0, r); chk("xor0_pixel", r, 1);

    // Clear request held in the very cycle the collision is set: set wins
    cclr = 1'b1;
    cpu_op(T_XOR, 6, 6, 1'b1, r);  chk("set_beats_clr", coll, 1);
    cclr = 1'b0;

    // Same-address write and scan in one cycle returns the old pixel
    @(negedge clk);
    req = 1'b1; op = T_WRITE; ax = 6'd7; ay = 5'd7; wd = 1'b1; sx = 6'd7; sy = 5'd7;
    @(posedge clk); #1;
    req = 1'b0; op = 2'd0;
    chk("scan_old_value", spix, 0);
    mdl[7 * W + 7] = 1'b1;
    @(posedge clk); #1 chk("scan_new_value", spix, 1);

    // Randomized CPU traffic against the model
    for (int k = 0; k < 300; k++) begin
      int x, y;
      x    = (k % 2) ? $urandom_range(0, W - 1) : $urandom_range(0, 3);
      y    = (k % 2) ? $urandom_range(0, H - 1) : $urandom_range(0, 3);
      cclr = ($urandom_range(0, 7) == 0);
      cpu_op(2'($urandom_range(1, 3)), x, y, 1'($urandom_range(0, 1)), r);
    end
    cclr = 1'b0;
    for (int k = 0; k < 64; k++)
      scan_chk("scan_rand", $urandom_range(0, W - 1), $urandom_range(0, H - 1));

    // Make sure the flag is set, then clear a filled screen
    cpu_op(T_WRITE, 9, 9, 1'b1, r);
    cpu_op(T_XOR, 9, 9, 1'b1, r);
    do_clear();
    chk("coll_kept_by_clear", coll, mcoll);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk); sx = 6'(i % W); sy = 5'(i / W);
      @(posedge clk); #1 if (spix !== 1'b0) bad++;
    end
    chk("scan_all_zero", bad, 0);

    // Clear arriving during XOR writeback is deferred until after it
    @(negedge clk);
    req = 1'b1; op = T_XOR; ax = 6'd10; ay = 5'd10; wd = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; op = 2'd0; clr = 1'b1;
    chk("ready_xor_wb_clr", ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    chk("pend_not_busy", busy, 0);
    chk("pend_ready", ready, 0);
    @(posedge clk); #1;
    chk("pend_clear_start", busy, 1);
    sx = 6'd10; sy = 5'd10;
    @(posedge clk); #1 chk("xor_before_clear", spix, 1);
    n = 0;
    while (busy && n < 3000) begin n++; @(posedge clk); #1; end
    chk("pend_clear_len", n, N - 1);
    chk("pend_clear_done", done, 1);
    for (int i = 0; i < N; i++) mdl[i] = 1'b0;
    scan_chk("pixel_cleared_after_xor", 10, 10);

    // Clear and request together: the request is refused
    @(negedge clk);
    clr = 1'b1; req = 1'b1; op = T_READ; ax = 6'd1; ay = 5'd1;
    #1 chk("ready_clr_req", ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b0; op = 2'd0;
    chk("no_rvalid_on_clear", rvalid, 0);
    chk("clr_req_busy", busy, 1);
    n = 0;
    while (busy && n < 3000) begin n++; @(posedge clk); #1; end
    chk("clr_req_len", n, N);

    // 128x64 instance: corner pixel, long clear, reset mid-clear
    @(negedge clk); reset2 = 1'b0;
    #1 chk("ready2_after_reset", ready2, 1);
    @(negedge clk);
    req2 = 1'b1; op2 = T_WRITE; ax2 = 7'd127; ay2 = 6'd63; wd2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0; op2 = 2'd0; sx2 = 7'd127; sy2 = 6'd63;
    @(posedge clk); #1 chk("scan2_corner", spix2, 1);
    @(negedge clk); clr2 = 1'b1;
    @(posedge clk); #1 clr2 = 1'b0;
    n = 0;
    while (busy2 && n < 10000) begin n++; @(posedge clk); #1; end
    chk("busy2_cycles", n, 8192);
    chk("done2_pulse", done2, 1);
    @(posedge clk); #1 chk("scan2_corner_cleared", spix2, 0);
    @(negedge clk);
    req2 = 1'b1; op2 = T_WRITE; wd2 = 1'b1;
    @(posedge clk); #1 req2 = 1'b0; op2 = 2'd0;
    @(negedge clk); clr2 = 1'b1;
    @(posedge clk); #1 clr2 = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk); reset2 = 1'b1;
    @(posedge clk); #1;
    chk("busy2_after_reset", busy2, 0);
    chk("done2_after_reset", done2, 0);
    chk("scan2_reset", spix2, 0);
    @(negedge clk); reset2 = 1'b0;
    #1 chk("ready2_after_reset2", ready2, 1);
    @(posedge clk); #1 chk("scan2_corner_kept", spix2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
